// File: rtl/rv32_prog_loader_pkg.sv
// Shared types and constants for the RV32 program loader.
//   state_e      : loader FSM states
//   cmd_op_e     : LOAD / RUN command opcode
//   cmd_target_e : imem / dmem selection for LOAD
//   DEFAULT_TIMEOUT_CYCLES : default run-phase watchdog limit
package rv32_prog_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    typedef enum logic {
        OP_LOAD = 1'b0,
        OP_RUN  = 1'b1
    } cmd_op_e;

    typedef enum logic {
        TGT_IMEM = 1'b0,
        TGT_DMEM = 1'b1
    } cmd_target_e;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1000000;

    // Hart index width; never zero so a single-hart build still has a field.
    function automatic int hart_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rv32_prog_loader_if.sv
// Command and word-stream bundle for the program loader.
//   cmd_*  : command handshake (valid/ready) and command fields
//   s_*    : word stream feeding LOAD (valid/ready/data)
// master = command/stream producer, slave = loader.
interface rv32_prog_loader_if
    import rv32_prog_loader_pkg::*;
#(
    parameter int NUM_HARTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16
);
    localparam int HART_W = hart_w(NUM_HARTS);

    logic                 cmd_valid;
    logic                 cmd_ready;
    cmd_op_e              cmd_op;
    cmd_target_e          cmd_target;
    logic [HART_W-1:0]    cmd_hart;
    logic [ADDR_W-1:0]    cmd_base;
    logic [CNT_W-1:0]     cmd_count;
    logic [NUM_HARTS-1:0] cmd_hart_mask;

    logic                 s_valid;
    logic                 s_ready;
    logic [DATA_W-1:0]    s_data;

    modport master (
        output cmd_valid, cmd_op, cmd_target, cmd_hart, cmd_base, cmd_count,
               cmd_hart_mask, s_valid, s_data,
        input  cmd_ready, s_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_target, cmd_hart, cmd_base, cmd_count,
               cmd_hart_mask, s_valid, s_data,
        output cmd_ready, s_ready
    );
endinterface

// File: rtl/rv32_run_watchdog.sv
// Run-phase bookkeeping: cycle counter, sticky per-hart end flags and the
// completion / timeout compares.
//   start       : clear counter and flags (RUN command accepted)
//   active      : loader is in RUN this cycle
//   mask        : harts being run
//   hart_is_end : per-hart end indication
//   run_cycles  : RUN cycles elapsed (registered, holds after RUN)
//   all_end     : every masked hart has ended, counting this cycle's ends
//   limit_hit   : this RUN cycle brings run_cycles to TIMEOUT_CYCLES
module rv32_run_watchdog #(
    parameter int NUM_HARTS      = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 active,
    input  logic [NUM_HARTS-1:0] mask,
    input  logic [NUM_HARTS-1:0] hart_is_end,
    output logic [31:0]          run_cycles,
    output logic                 all_end,
    output logic                 limit_hit
);
    logic [31:0]          cnt_q, cnt_d;
    logic [NUM_HARTS-1:0] flags_q, flags_d, flags_now;

    always_comb begin
        // Unmasked harts never contribute, so a stray end is ignored.
        flags_now = flags_q | (hart_is_end & mask);
        cnt_d     = cnt_q;
        flags_d   = flags_q;
        if (start) begin
            cnt_d   = '0;
            flags_d = '0;
        end else if (active) begin
            cnt_d   = cnt_q + 32'd1;
            flags_d = flags_now;
        end
    end

    assign all_end    = active && ((flags_now & mask) == mask);
    assign limit_hit  = active && ((cnt_q + 32'd1) == 32'(TIMEOUT_CYCLES));
    assign run_cycles = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            flags_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
        end
    end
endmodule

// File: rtl/rv32_prog_loader.sv
// Program loader for a cluster of RV32 harts. LOAD streams words into one
// hart's imem or dmem while holding that hart in reset; RUN releases a set
// of harts and waits for all of them to end, with a cycle watchdog.
//   rv32_io_clk / rv32_io_rst_n : clock, synchronous active-low reset
//   ldr                         : command + word-stream bundle (slave side)
//   imem_w_en / dmem_w_en       : per-hart write strobes
//   mem_addr / mem_data         : shared write address / data
//   core_rst_n                  : per-hart core reset, active-low
//   hart_is_end                 : per-hart end indication
//   busy / done / timeout       : status; done and timeout are 1-cycle pulses
//   run_cycles / load_words     : last RUN duration / last LOAD size
module rv32_prog_loader
    import rv32_prog_loader_pkg::*;
#(
    parameter int NUM_HARTS      = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 rv32_io_clk,
    input  logic                 rv32_io_rst_n,
    rv32_prog_loader_if.slave    ldr,
    output logic [NUM_HARTS-1:0] imem_w_en,
    output logic [NUM_HARTS-1:0] dmem_w_en,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_data,
    output logic [NUM_HARTS-1:0] core_rst_n,
    input  logic [NUM_HARTS-1:0] hart_is_end,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [31:0]          run_cycles,
    output logic [CNT_W-1:0]     load_words
);
    localparam int HART_W = hart_w(NUM_HARTS);

    state_e               state_q, state_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 s_ready_q, s_ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 timeout_q, timeout_d;
    logic [NUM_HARTS-1:0] imem_w_en_q, imem_w_en_d;
    logic [NUM_HARTS-1:0] dmem_w_en_q, dmem_w_en_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_data_q, mem_data_d;
    logic [NUM_HARTS-1:0] core_rst_n_q, core_rst_n_d;
    logic [CNT_W-1:0]     load_words_q, load_words_d;
    cmd_target_e          tgt_q, tgt_d;
    logic [HART_W-1:0]    hart_q, hart_d;
    logic [ADDR_W-1:0]    ptr_q, ptr_d;       // next write address
    logic [CNT_W-1:0]     left_q, left_d;     // words still to accept
    logic [CNT_W-1:0]     count_q, count_d;
    logic [NUM_HARTS-1:0] mask_q, mask_d;

    logic wd_start, wd_active, wd_all_end, wd_limit;

    rv32_run_watchdog #(
        .NUM_HARTS      (NUM_HARTS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wd (
        .clk         (rv32_io_clk),
        .rst_n       (rv32_io_rst_n),
        .start       (wd_start),
        .active      (wd_active),
        .mask        (mask_q),
        .hart_is_end (hart_is_end),
        .run_cycles  (run_cycles),
        .all_end     (wd_all_end),
        .limit_hit   (wd_limit)
    );

    always_comb begin
        state_d      = state_q;
        cmd_ready_d  = cmd_ready_q;
        s_ready_d    = s_ready_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        timeout_d    = 1'b0;
        imem_w_en_d  = '0;
        dmem_w_en_d  = '0;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        core_rst_n_d = core_rst_n_q;
        load_words_d = load_words_q;
        tgt_d        = tgt_q;
        hart_d       = hart_q;
        ptr_d        = ptr_q;
        left_d       = left_q;
        count_d      = count_q;
        mask_d       = mask_q;
        wd_start     = 1'b0;
        wd_active    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ldr.cmd_valid && cmd_ready_q) begin
                    if (ldr.cmd_op == OP_LOAD) begin
                        // Empty load completes on the spot, never entering LOAD.
                        if (ldr.cmd_count == '0) begin
                            done_d       = 1'b1;
                            load_words_d = '0;
                        end else begin
                            tgt_d       = ldr.cmd_target;
                            hart_d      = ldr.cmd_hart;
                            ptr_d       = ldr.cmd_base;
                            left_d      = ldr.cmd_count;
                            count_d     = ldr.cmd_count;
                            core_rst_n_d[ldr.cmd_hart] = 1'b0;
                            state_d     = ST_LOAD;
                            cmd_ready_d = 1'b0;
                            s_ready_d   = 1'b1;
                            busy_d      = 1'b1;
                        end
                    end else begin
                        mask_d   = ldr.cmd_hart_mask;
                        wd_start = 1'b1;
                        if (ldr.cmd_hart_mask == '0) begin
                            done_d = 1'b1;
                        end else begin
                            core_rst_n_d = core_rst_n_q | ldr.cmd_hart_mask;
                            state_d      = ST_RUN;
                            cmd_ready_d  = 1'b0;
                            busy_d       = 1'b1;
                        end
                    end
                end
            end
            ST_LOAD: begin
                if (ldr.s_valid && s_ready_q) begin
                    if (tgt_q == TGT_IMEM) imem_w_en_d[hart_q] = 1'b1;
                    else                   dmem_w_en_d[hart_q] = 1'b1;
                    mem_addr_d = ptr_q;
                    mem_data_d = ldr.s_data;
                    ptr_d      = ptr_q + ADDR_W'(1);   // wraps modulo 2^ADDR_W
                    left_d     = left_q - CNT_W'(1);
                    if (left_q == CNT_W'(1)) begin
                        done_d       = 1'b1;
                        load_words_d = count_q;
                        state_d      = ST_IDLE;
                        cmd_ready_d  = 1'b1;
                        s_ready_d    = 1'b0;
                        busy_d       = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                wd_active = 1'b1;
                // Completion takes priority over a coincident timeout.
                if (wd_all_end) begin
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end else if (wd_limit) begin
                    timeout_d    = 1'b1;
                    core_rst_n_d = core_rst_n_q & ~mask_q;
                    state_d      = ST_IDLE;
                    cmd_ready_d  = 1'b1;
                    busy_d       = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                s_ready_d   = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge rv32_io_clk) begin
        if (!rv32_io_rst_n) begin
            state_q      <= ST_IDLE;
            cmd_ready_q  <= 1'b1;
            s_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            imem_w_en_q  <= '0;
            dmem_w_en_q  <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            core_rst_n_q <= '0;
            load_words_q <= '0;
            tgt_q        <= TGT_IMEM;
            hart_q       <= '0;
            ptr_q        <= '0;
            left_q       <= '0;
            count_q      <= '0;
            mask_q       <= '0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            s_ready_q    <= s_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            imem_w_en_q  <= imem_w_en_d;
            dmem_w_en_q  <= dmem_w_en_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            core_rst_n_q <= core_rst_n_d;
            load_words_q <= load_words_d;
            tgt_q        <= tgt_d;
            hart_q       <= hart_d;
            ptr_q        <= ptr_d;
            left_q       <= left_d;
            count_q      <= count_d;
            mask_q       <= mask_d;
        end
    end

    assign ldr.cmd_ready = cmd_ready_q;
    assign ldr.s_ready   = s_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign timeout       = timeout_q;
    assign imem_w_en     = imem_w_en_q;
    assign dmem_w_en     = dmem_w_en_q;
    assign mem_addr      = mem_addr_q;
    assign mem_data      = mem_data_q;
    assign core_rst_n    = core_rst_n_q;
    assign load_words    = load_words_q;
endmodule

// File: tb/tb_rv32_prog_loader.sv
// Directed self-checking bench for rv32_prog_loader (2 harts, 20-cycle watchdog).
module tb_rv32_prog_loader;
    import rv32_prog_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  imem_w_en, dmem_w_en, core_rst_n, hart_is_end;
    logic [31:0] mem_addr, mem_data, run_cycles;
    logic        busy, done, timeout;
    logic [15:0] load_words;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rv32_prog_loader_if #(.NUM_HARTS(2), .ADDR_W(32), .DATA_W(32), .CNT_W(16)) bus ();

    rv32_prog_loader #(
        .NUM_HARTS(2), .ADDR_W(32), .DATA_W(32), .CNT_W(16), .TIMEOUT_CYCLES(20)
    ) dut (
        .rv32_io_clk   (clk),
        .rv32_io_rst_n (rst_n),
        .ldr           (bus.slave),
        .imem_w_en     (imem_w_en),
        .dmem_w_en     (dmem_w_en),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .core_rst_n    (core_rst_n),
        .hart_is_end   (hart_is_end),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .run_cycles    (run_cycles),
        .load_words    (load_words)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input cmd_op_e op, input cmd_target_e tgt, input logic hart,
                            input logic [31:0] base, input logic [15:0] count,
                            input logic [1:0] mask);
        bus.cmd_valid     = 1'b1;
        bus.cmd_op        = op;
        bus.cmd_target    = tgt;
        bus.cmd_hart      = hart;
        bus.cmd_base      = base;
        bus.cmd_count     = count;
        bus.cmd_hart_mask = mask;
        tick;
        bus.cmd_valid     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = OP_LOAD; bus.cmd_target = TGT_IMEM;
        bus.cmd_hart = 1'b0; bus.cmd_base = '0; bus.cmd_count = '0;
        bus.cmd_hart_mask = '0; bus.s_valid = 1'b0; bus.s_data = '0;
        hart_is_end = '0;

        // Reset state
        repeat (3) tick;
        check("rst_core_rst_n", core_rst_n, 2'b00);
        check("rst_strobes", {imem_w_en, dmem_w_en}, 4'b0000);
        check("rst_status", {busy, done, timeout}, 3'b000);
        check("rst_run_cycles", run_cycles, 0);
        check("rst_load_words", load_words, 0);
        rst_n = 1'b1;
        tick;
        check("rst_cmd_ready", bus.cmd_ready, 1'b1);

        // LOAD imem hart 1, base 0x10, three words with a stall before the last
        send_cmd(OP_LOAD, TGT_IMEM, 1'b1, 32'h10, 16'd3, 2'b00);
        check("ld1_busy_rdy", {busy, bus.cmd_ready, bus.s_ready}, 3'b101);
        check("ld1_no_strobe", imem_w_en, 2'b00);
        bus.s_valid = 1'b1; bus.s_data = 32'hAAAA_0001;
        tick;
        check("ld1_w0", {imem_w_en, dmem_w_en, mem_addr, mem_data}, {4'b1000, 32'h10, 32'hAAAA_0001});
        check("ld1_w0_done", done, 1'b0);
        bus.s_data = 32'hBBBB_0002;
        tick;
        check("ld1_w1", {imem_w_en, mem_addr, mem_data}, {2'b10, 32'h11, 32'hBBBB_0002});
        bus.s_valid = 1'b0;
        tick;
        tick;
        check("ld1_stall", {imem_w_en, busy, done}, 4'b0010);
        bus.s_valid = 1'b1; bus.s_data = 32'hCCCC_0003;
        tick;
        bus.s_valid = 1'b0;
        check("ld1_w2", {imem_w_en, dmem_w_en, mem_addr, mem_data}, {4'b1000, 32'h12, 32'hCCCC_0003});
        check("ld1_done", {done, load_words}, {1'b1, 16'd3});
        check("ld1_hart1_held", core_rst_n, 2'b00);
        tick;
        check("ld1_after", {imem_w_en, done, busy, bus.cmd_ready}, 5'b00001);

        // LOAD dmem hart 0 at the top of the address space: wraps to 0
        send_cmd(OP_LOAD, TGT_DMEM, 1'b0, 32'hFFFF_FFFF, 16'd2, 2'b00);
        bus.s_valid = 1'b1; bus.s_data = 32'hD000_0000;
        tick;
        check("ld2_w0", {imem_w_en, dmem_w_en, mem_addr}, {4'b0001, 32'hFFFF_FFFF});
        bus.s_data = 32'hD000_0001;
        tick;
        bus.s_valid = 1'b0;
        check("ld2_w1", {dmem_w_en, mem_addr, mem_data}, {2'b01, 32'h0, 32'hD000_0001});
        check("ld2_done", {done, load_words}, {1'b1, 16'd2});
        tick;

        // Empty LOAD: immediate done, no stream, no write
        send_cmd(OP_LOAD, TGT_IMEM, 1'b1, 32'h40, 16'd0, 2'b00);
        check("ld0_done", {done, bus.s_ready, imem_w_en, dmem_w_en, load_words}, {1'b1, 1'b0, 4'b0000, 16'd0});
        tick;
        check("ld0_after", {done, bus.cmd_ready}, 2'b01);

        // RUN both harts: hart 0 ends at cycle 5, hart 1 at cycle 9
        send_cmd(OP_RUN, TGT_IMEM, 1'b0, 32'h0, 16'd0, 2'b11);
        check("run1_start", {core_rst_n, busy, run_cycles}, {2'b11, 1'b1, 32'd0});
        for (int c = 0; c < 10; c++) begin
            hart_is_end = (c == 5) ? 2'b01 : (c == 9) ? 2'b10 : 2'b00;
            tick;
            hart_is_end = 2'b00;
            if (c == 6) check("run1_no_early_done", done, 1'b0);
        end
        check("run1_done", {done, timeout, core_rst_n, run_cycles}, {2'b10, 2'b11, 32'd10});
        tick;
        check("run1_single_pulse", {done, bus.cmd_ready, core_rst_n}, 4'b0111);

        // RUN hart 0 only: end from unmasked hart 1 is ignored
        send_cmd(OP_RUN, TGT_IMEM, 1'b0, 32'h0, 16'd0, 2'b01);
        for (int c = 0; c < 5; c++) begin
            hart_is_end = (c == 2) ? 2'b10 : (c == 4) ? 2'b01 : 2'b00;
            tick;
            hart_is_end = 2'b00;
            if (c == 2) check("run2_ignore_unmasked", done, 1'b0);
        end
        check("run2_done", {done, run_cycles}, {1'b1, 32'd5});
        tick;

        // RUN timeout: nobody ends, watchdog fires at run_cycles = 20
        send_cmd(OP_RUN, TGT_IMEM, 1'b0, 32'h0, 16'd0, 2'b11);
        repeat (19) tick;
        check("run3_pre_timeout", {timeout, busy, run_cycles}, {2'b01, 32'd19});
        tick;
        check("run3_timeout", {timeout, done, core_rst_n, run_cycles}, {2'b10, 2'b00, 32'd20});
        tick;
        check("run3_after", {timeout, bus.cmd_ready, run_cycles}, {2'b01, 32'd20});

        // End and limit in the same cycle: done wins
        send_cmd(OP_RUN, TGT_IMEM, 1'b0, 32'h0, 16'd0, 2'b01);
        repeat (19) tick;
        hart_is_end = 2'b01;
        tick;
        hart_is_end = 2'b00;
        check("run4_done_wins", {done, timeout, core_rst_n, run_cycles}, {2'b10, 2'b01, 32'd20});
        tick;

        // Empty RUN mask: immediate done, counter cleared
        send_cmd(OP_RUN, TGT_IMEM, 1'b0, 32'h0, 16'd0, 2'b00);
        check("run0_done", {done, busy, run_cycles, core_rst_n}, {2'b10, 32'd0, 2'b01});
        tick;

        // Release hart 1 too, then abort a LOAD on hart 0 with reset
        send_cmd(OP_RUN, TGT_IMEM, 1'b0, 32'h0, 16'd0, 2'b10);
        hart_is_end = 2'b10;
        tick;
        hart_is_end = 2'b00;
        check("run5_done", {done, core_rst_n}, 3'b111);
        tick;
        send_cmd(OP_LOAD, TGT_IMEM, 1'b0, 32'h100, 16'd5, 2'b00);
        check("ld3_hold_hart0_only", core_rst_n, 2'b10);
        bus.s_valid = 1'b1; bus.s_data = 32'h1;
        tick;
        bus.s_data = 32'h2;
        tick;
        bus.s_valid = 1'b0;
        check("ld3_partial_w1", {imem_w_en, mem_addr, done}, {2'b01, 32'h101, 1'b0});
        rst_n = 1'b0;
        tick;
        check("ld3_reset", {done, timeout, busy, core_rst_n, imem_w_en, load_words}, {3'b000, 2'b00, 2'b00, 16'd0});
        rst_n = 1'b1;
        tick;
        check("ld3_after_release", {bus.cmd_ready, done, busy}, 3'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
